// File: rtl/bsg_regbank_pkg.sv
// Shared types and constants for the BSG register bank.
// The optional interrupt event counter is enabled with `define BSG_IRQ_COUNT_EN.
package bsg_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned TXEN_BIT    = 0;
  localparam int unsigned INTMSK_BIT  = 1;
  localparam int unsigned INTFLAG_BIT = 2;
  localparam int unsigned BUSY_BIT    = 3;

  // Offset of addr from base, wrapped modulo 2^aw.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned aw);
    logic [63:0] diff;
    diff = {32'b0, addr} - {32'b0, base};
    return 32'(diff & ((64'd1 << aw) - 64'd1));
  endfunction

endpackage

// File: rtl/bsg_regbank_irq.sv
// INTFLAG set/W1C logic, registered irq and (with BSG_IRQ_COUNT_EN) a
// saturating interrupt event counter cleared on read.
module bsg_regbank_irq
  import bsg_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hw_done_i,
  input  logic              intmsk_i,
  input  logic              w1c_i,
`ifdef BSG_IRQ_COUNT_EN
  input  logic              cnt_rd_i,
  output logic [DATA_W-1:0] cnt_o,
`endif
  output logic              intflag_o,
  output logic              irq_o
);

  logic intflag_q, intflag_d;
  logic irq_q;
  logic set_evt;

  assign set_evt = hw_done_i & intmsk_i;

  // A set event in the same cycle as W1C takes priority.
  always_comb begin
    intflag_d = intflag_q;
    if (set_evt)    intflag_d = 1'b1;
    else if (w1c_i) intflag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intflag_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      intflag_q <= intflag_d;
      irq_q     <= intflag_q & intmsk_i;
    end
  end

  assign intflag_o = intflag_q;
  assign irq_o     = irq_q;

`ifdef BSG_IRQ_COUNT_EN
  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_rd_i)                  cnt_d = set_evt ? DATA_W'(1) : '0;
    else if (set_evt && cnt_q != '1) cnt_d = cnt_q + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/bsg_regbank.sv
// Bus-slave register bank: BSG_CONTROL, N_CH data channels, registered response.
// Optional interrupt event counter at BASE_ADDR+N_CH+1 via `define BSG_IRQ_COUNT_EN.
module bsg_regbank
  import bsg_regbank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       N_CH      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_valid,
  input  logic                   bus_write,
  input  logic [ADDR_W-1:0]      bus_addr,
  input  logic [DATA_W-1:0]      bus_wdata,
  output logic                   bus_ready,
  output logic                   bus_rvalid,
  output logic [DATA_W-1:0]      bus_rdata,
  output logic                   bus_err,
  output logic [2:0]             ctrl_out,
  input  logic [DATA_W-4:0]      hw_status,
  input  logic                   hw_done,
  output logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_load,
  output logic                   irq
);

  localparam int unsigned CH_IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e            state_q, state_d;
  logic              txen_q, txen_d, intmsk_q, intmsk_d;
  logic              intflag, w1c;
  logic [DATA_W-1:0] ch_q [N_CH];
  logic [N_CH-1:0]   ch_load_q, hold_load;
  logic [CH_IW-1:0]  hold_idx_q, hold_idx_d, dec_idx, wr_idx;
  logic [DATA_W-1:0] hold_data_q, hold_data_d, wr_data, rdata_q, rdata_d;
  logic              err_q, err_d, ch_we, hold_commit;
  logic [31:0]       off;
  logic              hit_ctrl, hit_ch, hit_cnt, accept, busy;
`ifdef BSG_IRQ_COUNT_EN
  logic              cnt_rd;
  logic [DATA_W-1:0] irq_cnt;
`endif

  assign off      = addr_offset(32'(bus_addr), 32'(BASE_ADDR), ADDR_W);
  assign hit_ctrl = (off == 32'd0);
  assign hit_ch   = (off >= 32'd1) && (off <= N_CH);
  assign dec_idx  = CH_IW'(off - 32'd1);
`ifdef BSG_IRQ_COUNT_EN
  assign hit_cnt  = (off == N_CH + 1);
`else
  assign hit_cnt  = 1'b0;
`endif

  assign busy      = hw_status[BUSY_BIT-3];
  assign bus_ready = rst_n & (state_q == IDLE);
  assign accept    = bus_valid & bus_ready;

  always_comb begin
    state_d     = state_q;
    txen_d      = txen_q;
    intmsk_d    = intmsk_q;
    w1c         = 1'b0;
    ch_we       = 1'b0;
    hold_commit = 1'b0;
    wr_idx      = dec_idx;
    wr_data     = bus_wdata;
    hold_idx_d  = hold_idx_q;
    hold_data_d = hold_data_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef BSG_IRQ_COUNT_EN
    cnt_rd      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b0;
          if (bus_write) begin
            if (hit_ctrl) begin
              txen_d   = bus_wdata[TXEN_BIT];
              intmsk_d = bus_wdata[INTMSK_BIT];
              w1c      = bus_wdata[INTFLAG_BIT];
            end else if (hit_ch) begin
              if (busy) begin
                state_d     = HOLD;
                hold_idx_d  = dec_idx;
                hold_data_d = bus_wdata;
              end else begin
                ch_we = 1'b1;
              end
            end else if (!hit_cnt) begin
              err_d = 1'b1;
            end
          end else begin
            if (hit_ctrl)    rdata_d = {hw_status, intflag, intmsk_q, txen_q};
            else if (hit_ch) rdata_d = ch_q[dec_idx];
`ifdef BSG_IRQ_COUNT_EN
            else if (hit_cnt) begin
              rdata_d = irq_cnt;
              cnt_rd  = 1'b1;
            end
`endif
            else             err_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!busy) begin
          state_d     = RESP;
          ch_we       = 1'b1;
          hold_commit = 1'b1;
          wr_idx      = hold_idx_q;
          wr_data     = hold_data_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Held commits pulse ch_load during the releasing HOLD cycle itself;
  // direct writes pulse it in the cycle after the accept edge.
  assign hold_load = hold_commit ? (N_CH'(1) << hold_idx_q) : '0;
  assign ch_load   = ch_load_q | hold_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      txen_q      <= 1'b0;
      intmsk_q    <= 1'b0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ch_load_q   <= '0;
      for (int unsigned k = 0; k < N_CH; k++) ch_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      txen_q      <= txen_d;
      intmsk_q    <= intmsk_d;
      hold_idx_q  <= hold_idx_d;
      hold_data_q <= hold_data_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ch_load_q   <= '0;
      if (ch_we) begin
        ch_q[wr_idx] <= wr_data;
        if (!hold_commit) ch_load_q[wr_idx] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_data[k*DATA_W +: DATA_W] = ch_q[k];
  end

  bsg_regbank_irq #(
    .DATA_W (DATA_W)
  ) u_irq (
    .clk       (clk),
    .rst_n     (rst_n),
    .hw_done_i (hw_done),
    .intmsk_i  (intmsk_q),
    .w1c_i     (w1c),
`ifdef BSG_IRQ_COUNT_EN
    .cnt_rd_i  (cnt_rd),
    .cnt_o     (irq_cnt),
`endif
    .intflag_o (intflag),
    .irq_o     (irq)
  );

  assign ctrl_out   = {intflag, intmsk_q, txen_q};
  assign bus_rvalid = (state_q == RESP);
  assign bus_rdata  = rdata_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_bsg_regbank.sv
// Self-checking bench for bsg_regbank: directed table, hand-written corner
// sequences and randomized traffic against a register-level model.
module tb_bsg_regbank;

  localparam int unsigned NCH  = 2;
  localparam int          BASE = 16;
`ifdef BSG_IRQ_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid, bus_write;
  logic [7:0]  bus_addr, bus_wdata;
  logic        bus_ready, bus_rvalid, bus_err;
  logic [7:0]  bus_rdata;
  logic [2:0]  ctrl_out;
  logic [4:0]  hw_status;
  logic        hw_done;
  logic [15:0] ch_data;
  logic [1:0]  ch_load;
  logic        irq;

  bsg_regbank #(
    .DATA_W    (8),
    .ADDR_W    (8),
    .N_CH      (NCH),
    .BASE_ADDR (8'h10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err),
    .ctrl_out   (ctrl_out),
    .hw_status  (hw_status),
    .hw_done    (hw_done),
    .ch_data    (ch_data),
    .ch_load    (ch_load),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register-level model
  logic       m_txen, m_msk, m_flag;
  logic [7:0] m_ch [NCH];
  logic [7:0] m_cnt;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_txen = 0; m_msk = 0; m_flag = 0; m_cnt = 0;
    for (int k = 0; k < NCH; k++) m_ch[k] = 8'h00;
  endfunction

  function automatic void model_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                    input logic [4:0] st, output logic [7:0] rd, output logic er);
    int off;
    off = (int'(a) - BASE + 256) % 256;
    rd = 8'h00;
    er = 1'b0;
    if (off == 0) begin
      if (wr) begin
        m_txen = d[0];
        m_msk  = d[1];
        if (d[2]) m_flag = 1'b0;
      end else begin
        rd = {st, m_flag, m_msk, m_txen};
      end
    end else if (off >= 1 && off <= NCH) begin
      if (wr) m_ch[off-1] = d;
      else    rd = m_ch[off-1];
    end else if (CNT_EN && off == NCH + 1) begin
      if (!wr) begin
        rd    = m_cnt;
        m_cnt = 8'h00;
      end
    end else begin
      er = 1'b1;
    end
  endfunction

  function automatic void model_done();
    if (m_msk) begin
      m_flag = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endfunction

  // One complete request; called and returns at posedge+1 with the slave idle.
  task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er, output logic ok);
    int n;
    bus_valid = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = d;
    n = 0;
    while (!bus_ready && n < 20) begin tick(); n++; end
    tick();
    bus_valid = 1'b0;
    n = 0;
    while (!bus_rvalid && n < 20) begin tick(); n++; end
    ok = bus_rvalid;
    rd = bus_rdata;
    er = bus_err;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bus_ready),  0);
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 0);
    chk({tag, "_rdata"},  32'(bus_rdata),  0);
    chk({tag, "_err"},    32'(bus_err),    0);
    chk({tag, "_ctrl"},   32'(ctrl_out),   0);
    chk({tag, "_chdata"}, 32'(ch_data),    0);
    chk({tag, "_chload"}, 32'(ch_load),    0);
    chk({tag, "_irq"},    32'(irq),        0);
  endtask

  initial begin
    logic [7:0] rd, erd;
    logic       er, eer, ok;
    logic [4:0] st;

    vt[0]  = '{1'b0, 8'h11, 8'h00, 8'hA5, 1'b0};
    vt[1]  = '{1'b1, 8'h12, 8'h5A, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 8'h12, 8'h00, 8'h5A, 1'b0};
    vt[3]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 8'h20, 8'hFF, 8'h00, 1'b1};
    vt[5]  = '{1'b0, 8'h0F, 8'h00, 8'h00, 1'b1};
    vt[6]  = '{1'b1, 8'h10, 8'hFB, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 8'h10, 8'h00, 8'h03, 1'b0};
    vt[8]  = '{1'b1, 8'h10, 8'h00, 8'h00, 1'b0};
    vt[9]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
    vt[10] = '{1'b0, 8'h13, 8'h00, 8'h00, !CNT_EN};
    vt[11] = '{1'b1, 8'h13, 8'h55, 8'h00, !CNT_EN};

    rst_n = 1'b0; bus_valid = 1'b0; bus_write = 1'b0; bus_addr = 8'h00;
    bus_wdata = 8'h00; hw_status = 5'h00; hw_done = 1'b0;
    model_reset();
    tick(); tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus_ready), 1);

    // Read BASE: response one cycle after accept, ready again after that
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 8'h10;
    tick();
    bus_valid = 1'b0;
    chk("rd10_rvalid", 32'(bus_rvalid), 1);
    chk("rd10_rdata",  32'(bus_rdata),  0);
    chk("rd10_err",    32'(bus_err),    0);
    chk("rd10_ready",  32'(bus_ready),  0);
    tick();
    chk("rd10_ready_back", 32'(bus_ready),  1);
    chk("rd10_rvalid_end", 32'(bus_rvalid), 0);

    // Direct channel write
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 8'h11; bus_wdata = 8'hA5;
    model_req(1'b1, 8'h11, 8'hA5, 5'h00, erd, eer);
    tick();
    bus_valid = 1'b0;
    chk("wr11_chdata", 32'(ch_data[7:0]), 32'hA5);
    chk("wr11_chload", 32'(ch_load), 32'b01);
    chk("wr11_rvalid", 32'(bus_rvalid), 1);
    chk("wr11_err",    32'(bus_err), 0);
    tick();
    chk("wr11_chload_end", 32'(ch_load), 0);
    chk("wr11_ready_back", 32'(bus_ready), 1);

    for (int i = 0; i < 12; i++) begin
      model_req(vt[i].wr, vt[i].addr, vt[i].wdata, hw_status, erd, eer);
      req(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, ok);
      chk($sformatf("vec%0d_rvalid", i), 32'(ok), 1);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
    end
    chk("vec_chdata", 32'(ch_data), 32'h5AA5);

    // Channel write held off by BUSY
    hw_status = 5'h01;
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 8'h12; bus_wdata = 8'h3C;
    model_req(1'b1, 8'h12, 8'h3C, 5'h01, erd, eer);
    tick();
    bus_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_ready", i),  32'(bus_ready),  0);
      chk($sformatf("hold%0d_rvalid", i), 32'(bus_rvalid), 0);
      chk($sformatf("hold%0d_chload", i), 32'(ch_load),    0);
      tick();
    end
    hw_status = 5'h00;
    #1;
    chk("hold_rel_chload", 32'(ch_load), 32'b10);
    chk("hold_rel_rvalid", 32'(bus_rvalid), 0);
    chk("hold_rel_chold",  32'(ch_data[15:8]), 32'h5A);
    tick();
    chk("hold_resp_rvalid", 32'(bus_rvalid), 1);
    chk("hold_resp_err",    32'(bus_err), 0);
    chk("hold_resp_chload", 32'(ch_load), 0);
    chk("hold_resp_chdata", 32'(ch_data[15:8]), 32'h3C);
    tick();
    chk("hold_ready_back", 32'(bus_ready), 1);

    // Interrupt set, irq one cycle later
    model_req(1'b1, 8'h10, 8'h02, 5'h00, erd, eer);
    req(1'b1, 8'h10, 8'h02, rd, er, ok);
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    model_done();
    chk("int_flag_set", 32'(ctrl_out), 32'b110);
    chk("int_irq_lag",  32'(irq), 0);
    tick();
    chk("int_irq", 32'(irq), 1);

    // W1C in the same cycle as hw_done: set wins
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 8'h10; bus_wdata = 8'h06;
    hw_done = 1'b1;
    model_req(1'b1, 8'h10, 8'h06, 5'h00, erd, eer);
    model_done();
    tick();
    bus_valid = 1'b0; hw_done = 1'b0;
    chk("w1c_race_flag",   32'(ctrl_out), 32'b110);
    chk("w1c_race_rvalid", 32'(bus_rvalid), 1);
    tick();

    // W1C alone
    model_req(1'b1, 8'h10, 8'h06, 5'h00, erd, eer);
    req(1'b1, 8'h10, 8'h06, rd, er, ok);
    chk("w1c_flag", 32'(ctrl_out), 32'b010);
    chk("w1c_irq",  32'(irq), 0);

    // Third event, then counter read-to-clear
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    model_done();
    tick();
    chk("int3_irq", 32'(irq), 1);
    for (int i = 0; i < 2; i++) begin
      model_req(1'b0, 8'h13, 8'h00, 5'h00, erd, eer);
      req(1'b0, 8'h13, 8'h00, rd, er, ok);
      chk($sformatf("cnt_rd%0d_err", i), 32'(er), 32'(!CNT_EN));
      chk($sformatf("cnt_rd%0d_data", i), 32'(rd),
          (CNT_EN && i == 0) ? 32'h03 : 32'h00);
    end

    // hw_done while masked is dropped
    model_req(1'b1, 8'h10, 8'h04, 5'h00, erd, eer);
    req(1'b1, 8'h10, 8'h04, rd, er, ok);
    hw_done = 1'b1;
    tick();
    hw_done = 1'b0;
    model_done();
    tick();
    chk("masked_done_ctrl", 32'(ctrl_out), 0);
    chk("masked_done_irq",  32'(irq), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic       wr;
      logic [7:0] a, d;
      chk($sformatf("rnd%0d_ctrl", i), 32'(ctrl_out), 32'({m_flag, m_msk, m_txen}));
      chk($sformatf("rnd%0d_irq", i),  32'(irq), 32'(m_flag & m_msk));
      if ($urandom_range(0, 5) == 0) begin
        hw_done = 1'b1;
        tick();
        hw_done = 1'b0;
        model_done();
        tick();
      end
      st = 5'($urandom) & 5'h1E;
      hw_status = st;
      wr = 1'($urandom);
      a  = 8'h0F + 8'($urandom_range(0, NCH + 3));
      d  = 8'($urandom);
      model_req(wr, a, d, st, erd, eer);
      req(wr, a, d, rd, er, ok);
      chk($sformatf("rnd%0d_rvalid", i), 32'(ok), 1);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eer));
      if (!wr) chk($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(erd));
      chk($sformatf("rnd%0d_chdata", i), 32'(ch_data), 32'({m_ch[1], m_ch[0]}));
    end

    // Reset asserted during HOLD
    hw_status = 5'h01;
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 8'h11; bus_wdata = 8'h77;
    tick();
    bus_valid = 1'b0;
    tick();
    chk("rsthold_in_hold", 32'(bus_ready), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rsthold");
    hw_status = 5'h00;
    tick();
    chk("rsthold_chload", 32'(ch_load), 0);
    chk("rsthold_chdata", 32'(ch_data), 0);
    rst_n = 1'b1;
    tick();
    chk("rsthold_chdata_after", 32'(ch_data), 0);
    chk("rsthold_ready_after",  32'(bus_ready), 1);
    chk("rsthold_rvalid_after", 32'(bus_rvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
